pwm_dac_stage: RTL

- Downstream consumer of the 8-bit waveform generators (triangle, sawtooth, sine).
- Converts one sample per PWM period into a single-bit PWM output that drives the board's RC-filtered audio/scope pin.
- Accepts samples through a valid/ready handshake and holds them in a one-entry buffer.
- Flags underrun when no fresh sample is present at a period boundary.

---
 rtl/dsp_pkg.sv | 9 +
 rtl/pwm_dac_stage_if.sv | 14 +
 rtl/pwm_prescaler.sv | 29 ++
 rtl/pwm_dac_stage.sv | 92 +++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared constants for the 8-bit waveform/DSP chain.
// Sample width and the PWM period derived from it.
package dsp_pkg;

  localparam int SAMPLE_W     = 8;
  localparam int PWM_PERIOD   = (1 << SAMPLE_W) - 1;
  localparam int PWM_MAX_DUTY = (1 << SAMPLE_W) - 1;

endpackage

// File: rtl/pwm_dac_stage_if.sv
// Sample valid/ready handshake into the PWM DAC stage.
// master drives data/valid, slave returns ready.
interface pwm_dac_stage_if #(
  parameter int WIDTH = dsp_pkg::SAMPLE_W
);

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/pwm_prescaler.sv
// Clock prescaler: one tick every PRESCALE enabled cycles.
// Count holds while en is low so timing resumes seamlessly.
module pwm_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] presc_cnt;

  assign tick = en && (presc_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else if (en) begin
      presc_cnt <= presc_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pwm_dac_stage.sv
// PWM DAC: one buffered sample per 2^WIDTH-1 tick period,
// compared against the phase counter to drive a 1-bit pin.
module pwm_dac_stage
  import dsp_pkg::*;
#(
  parameter int WIDTH    = SAMPLE_W,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  pwm_dac_stage_if.slave    smp,
  input  logic              underrun_clr,
  output logic              pwm_out,
  output logic              period_start,
  output logic              underrun
);

  localparam logic [WIDTH-1:0] PHASE_LAST =
    WIDTH'((1 << WIDTH) - 2);

  logic [WIDTH-1:0] phase;
  logic [WIDTH-1:0] duty;
  logic [WIDTH-1:0] pending;
  logic             pending_valid;
  logic             tick;
  logic             boundary;
  logic             accept;

  pwm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  assign boundary  = tick && (phase == PHASE_LAST);
  assign smp.ready = !pending_valid;
  assign accept    = smp.valid && !pending_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (boundary) begin
      phase <= '0;
    end else if (tick) begin
      phase <= phase + WIDTH'(1);
    end
  end

  // An accept on an empty-buffer boundary bypasses straight to duty.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty          <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
    end else if (boundary) begin
      if (pending_valid) begin
        duty          <= pending;
        pending_valid <= 1'b0;
      end else if (accept) begin
        duty <= smp.data;
      end
    end else if (accept) begin
      pending       <= smp.data;
      pending_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      underrun <= 1'b0;
    end else if (boundary && !pending_valid && !accept) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= en && (phase < duty);
      period_start <= boundary;
    end
  end

endmodule
